// File: rtl/miner_job_sequencer_if.sv
// ============================================================================
// Module  : miner_job_sequencer_if
// Brief   : Job-offer and result-pop handshakes of the miner job sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface miner_job_sequencer_if;
  logic         job_valid;
  logic         job_ready;
  logic [639:0] job_block;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_cycles;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;

  modport master (
    output job_valid, job_block, job_nonce_start, job_cycles, res_ready,
    input  job_ready, res_valid, res_nonce
  );

  modport slave (
    input  job_valid, job_block, job_nonce_start, job_cycles, res_ready,
    output job_ready, res_valid, res_nonce
  );
endinterface

`default_nettype wire

// File: rtl/miner_job_sequencer.sv
// ============================================================================
// Module  : miner_job_sequencer
// Brief   : Runs one skein miner through load/flush/scan jobs and queues hits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module miner_job_sequencer #(
  parameter int CORES        = 1,
  parameter int OFFSET       = 733,
  parameter int RESULT_DEPTH = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  miner_job_sequencer_if.slave   jif,
  input  wire logic              abort,
  output logic                   miner_reset,
  output logic [639:0]           miner_block,
  output logic [31:0]            miner_nonce_start,
  input  wire logic              miner_nonce_found,
  input  wire logic [31:0]       miner_nonce_out,
  output logic                   busy,
  output logic                   job_done,
  output logic [15:0]            drop_count
);

  generate
    if (CORES < 1 || OFFSET < 0 || RESULT_DEPTH < 2 ||
        (RESULT_DEPTH & (RESULT_DEPTH - 1)) != 0) begin : g_param_check
      $error("miner_job_sequencer: illegal parameter set");
    end
  endgenerate

  localparam int c_AW           = $clog2(RESULT_DEPTH);
  localparam int c_FW           = (OFFSET > 1) ? $clog2(OFFSET) : 1;
  localparam int c_FLUSH_LAST_I = (OFFSET > 0) ? OFFSET - 1 : 0;
  localparam logic [c_FW-1:0] c_FLUSH_LAST = c_FLUSH_LAST_I[c_FW-1:0];
  localparam logic [c_AW:0]   c_DEPTH      = RESULT_DEPTH[c_AW:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_SCAN  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_done_nxt;
  logic              r_job_done;
  logic              r_load_cnt;
  logic [c_FW-1:0]   r_flush_cnt;
  logic [31:0]       r_remaining;
  logic [639:0]      r_miner_block;
  logic [31:0]       r_miner_nonce_start;

  logic [31:0]       r_mem [RESULT_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic [15:0]       r_drop_count;

  logic w_accept;
  logic w_zero_job;
  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  assign jif.job_ready = (r_state == S_IDLE) && !abort && !reset;
  assign w_accept      = jif.job_valid && jif.job_ready;
  assign w_zero_job    = (jif.job_cycles == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_zero_job) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // Two reset cycles let the miner's own registered reset settle.
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_load_cnt) begin
          w_state_nxt = (OFFSET > 0) ? S_FLUSH : S_SCAN;
        end
      end
      S_FLUSH: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_flush_cnt == c_FLUSH_LAST) begin
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_remaining == 32'd1) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_job_done          <= 1'b0;
      r_load_cnt          <= 1'b0;
      r_flush_cnt         <= '0;
      r_remaining         <= 32'd0;
      r_miner_block       <= 640'd0;
      r_miner_nonce_start <= 32'd0;
    end else begin
      r_job_done  <= w_done_nxt;
      r_load_cnt  <= (r_state == S_LOAD) ? ~r_load_cnt : 1'b0;
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_miner_block       <= jif.job_block;
        r_miner_nonce_start <= jif.job_nonce_start;
        r_remaining         <= jif.job_cycles;
      end else if (r_state == S_SCAN) begin
        r_remaining <= r_remaining - 32'd1;
      end
    end
  end

  assign miner_reset       = reset || (r_state == S_IDLE) || (r_state == S_LOAD);
  assign miner_block       = r_miner_block;
  assign miner_nonce_start = r_miner_nonce_start;
  assign busy              = (r_state != S_IDLE);
  assign job_done          = r_job_done;

  // Hits are only meaningful in SCAN; an abort cycle still keeps its hit.
  assign w_push_req = (r_state == S_SCAN) && miner_nonce_found;
  assign w_pop      = jif.res_valid && jif.res_ready;
  assign w_full     = (r_count == c_DEPTH);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= miner_nonce_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_count <= 16'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign jif.res_valid = (r_count != '0);
  assign jif.res_nonce = jif.res_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign drop_count    = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_miner_job_sequencer.sv
// ============================================================================
// Module  : tb_miner_job_sequencer
// Brief   : Directed scoreboard bench for miner_job_sequencer (OFFSET=4, depth 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_miner_job_sequencer;
  localparam int OFFSET = 4;
  localparam int DEPTH  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         abort = 1'b0;
  logic         miner_reset;
  logic [639:0] miner_block;
  logic [31:0]  miner_nonce_start;
  logic         miner_nonce_found;
  logic [31:0]  miner_nonce_out;
  logic         busy;
  logic         job_done;
  logic [15:0]  drop_count;

  miner_job_sequencer_if jif();

  miner_job_sequencer #(
    .CORES(1), .OFFSET(OFFSET), .RESULT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .jif(jif), .abort(abort),
    .miner_reset(miner_reset), .miner_block(miner_block),
    .miner_nonce_start(miner_nonce_start),
    .miner_nonce_found(miner_nonce_found), .miner_nonce_out(miner_nonce_out),
    .busy(busy), .job_done(job_done), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_done = 0;
  logic [31:0] exp_q[$];

  // Miner model: 0 quiet, 1 single hit at scan index hit_idx,
  // 2 hit on every pipeline-fill cycle, 3 hit on every scan cycle.
  int          mode    = 0;
  int          hit_idx = 0;
  logic [31:0] job_ns  = 32'd0;
  int          m_p     = -1;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    miner_nonce_found = 1'b0;
    miner_nonce_out   = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (miner_reset === 1'b1) m_p = -1;
      else m_p++;
      miner_nonce_found = 1'b0;
      miner_nonce_out   = 32'hDEAD0000 ^ 32'(m_p);
      if (m_p >= 0) begin
        case (mode)
          1: if (m_p - OFFSET == hit_idx) begin
               miner_nonce_found = 1'b1;
               miner_nonce_out   = job_ns + 32'(m_p - OFFSET);
             end
          2: if (m_p < OFFSET) miner_nonce_found = 1'b1;
          3: if (m_p >= OFFSET) begin
               miner_nonce_found = 1'b1;
               miner_nonce_out   = job_ns + 32'(m_p - OFFSET);
             end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard monitor: every result popped must match the next expected nonce.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (job_done === 1'b1) n_done++;
      if (jif.res_valid === 1'b1 && jif.res_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL res_unexpected: got 0x%0h, want no result", jif.res_nonce);
        end else begin
          e = exp_q.pop_front();
          chk("res_nonce", {608'd0, jif.res_nonce}, {608'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic offer(input logic [639:0] b, input logic [31:0] ns, input logic [31:0] c);
    bit ok;
    ok = 1'b0;
    jif.job_block       = b;
    jif.job_nonce_start = ns;
    jif.job_cycles      = c;
    jif.job_valid       = 1'b1;
    job_ns              = ns;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (jif.job_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("offer_timeout", 0, 1);
    @(posedge clk);
    #1;
    jif.job_valid = 1'b0;
  endtask

  // Counts cycles with job_ready low; returns on the negedge of IDLE entry.
  task automatic wait_end(output int len);
    len = 0;
    @(negedge clk);
    while (jif.job_ready !== 1'b1 && len < 3000) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int len;
    int d0;
    jif.job_valid       = 1'b0;
    jif.job_block       = 640'd0;
    jif.job_nonce_start = 32'd0;
    jif.job_cycles      = 32'd0;
    jif.res_ready       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_job_ready",   jif.job_ready, 0);
    chk("rst_miner_reset", miner_reset, 1);
    chk("rst_miner_block", miner_block, 0);
    chk("rst_nonce_start", miner_nonce_start, 0);
    chk("rst_res_valid",   jif.res_valid, 0);
    chk("rst_res_nonce",   jif.res_nonce, 0);
    chk("rst_busy",        busy, 0);
    chk("rst_job_done",    job_done, 0);
    chk("rst_drop_count",  drop_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    jif.res_ready = 1'b1;

    // Basic job with a single hit at nonce 0x105
    mode = 1; hit_idx = 5;
    exp_q.push_back(32'h105);
    d0 = n_done;
    offer({20{32'hA5A5_0001}}, 32'h100, 32'd10);
    chk("basic_block", miner_block, {20{32'hA5A5_0001}});
    chk("basic_nonce_start", miner_nonce_start, 32'h100);
    chk("basic_busy", busy, 1);
    chk("basic_load_reset", miner_reset, 1);
    wait_end(len);
    chk("basic_len", len, 16);
    chk("basic_done_at_idle", job_done, 1);
    chk("basic_busy_idle", busy, 0);
    @(negedge clk);
    chk("basic_done_one_cycle", job_done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("basic_done_count", n_done - d0, 1);
    chk("basic_q_empty", exp_q.size(), 0);

    // Hits during pipeline fill are discarded
    mode = 2;
    d0 = n_done;
    offer({20{32'h0000_0B0B}}, 32'h500, 32'd5);
    wait_end(len);
    chk("flush_len", len, 11);
    @(posedge clk);
    #1;
    chk("flush_res_valid", jif.res_valid, 0);
    chk("flush_drop", drop_count, 0);
    chk("flush_done_count", n_done - d0, 1);

    // Overflow: 6 hits into a 4-deep FIFO with no pops
    jif.res_ready = 1'b0;
    mode = 3;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h2000 + 32'(i));
    offer({20{32'h0000_0C0C}}, 32'h2000, 32'd6);
    wait_end(len);
    chk("ovf_len", len, 12);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_res_valid", jif.res_valid, 1);
    chk("ovf_head", jif.res_nonce, 32'h2000);
    @(posedge clk);
    #1;
    jif.res_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ovf_drained", jif.res_valid, 0);
    chk("ovf_q_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Zero-length job followed immediately by a second job
    mode = 0;
    d0 = n_done;
    offer({20{32'h0000_0D0D}}, 32'h600, 32'd0);
    jif.job_block       = {20{32'h0000_0E0E}};
    jif.job_nonce_start = 32'h700;
    jif.job_cycles      = 32'd3;
    jif.job_valid       = 1'b1;
    job_ns              = 32'h700;
    @(negedge clk);
    chk("zero_done", job_done, 1);
    chk("zero_miner_reset", miner_reset, 1);
    chk("zero_busy", busy, 0);
    chk("b2b_ready", jif.job_ready, 1);
    @(posedge clk);
    #1;
    jif.job_valid = 1'b0;
    chk("b2b_block", miner_block, {20{32'h0000_0E0E}});
    wait_end(len);
    chk("b2b_len", len, 9);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_done_count", n_done - d0, 2);

    // Abort at scan cycle 3 of 20 with a simultaneous hit
    mode = 1; hit_idx = 2;
    exp_q.push_back(32'h3002);
    d0 = n_done;
    offer({20{32'h0000_0F0F}}, 32'h3000, 32'd20);
    repeat (8) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_in_scan", miner_reset, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_miner_reset", miner_reset, 1);
    chk("abort_busy", busy, 0);
    chk("abort_job_ready", jif.job_ready, 1);
    chk("abort_no_done", job_done, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_done_count", n_done - d0, 0);
    chk("abort_q_empty", exp_q.size(), 0);

    // Reset during FLUSH with two results held
    jif.res_ready = 1'b0;
    mode = 3;
    offer({20{32'h0000_1111}}, 32'h4000, 32'd2);
    wait_end(len);
    chk("pre_rst_len", len, 8);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", jif.res_valid, 1);
    chk("pre_rst_head", jif.res_nonce, 32'h4000);
    mode = 0;
    d0 = n_done;
    offer({20{32'h0000_2222}}, 32'h5000, 32'd50);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_flush", miner_reset, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_miner_reset", miner_reset, 1);
    chk("mid_rst_block", miner_block, 0);
    chk("mid_rst_nonce_start", miner_nonce_start, 0);
    chk("mid_rst_res_valid", jif.res_valid, 0);
    chk("mid_rst_res_nonce", jif.res_nonce, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_job_ready", jif.job_ready, 0);
    chk("mid_rst_drop", drop_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    jif.res_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("post_rst_done_count", n_done - d0, 0);
    chk("post_rst_res_valid", jif.res_valid, 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/miner_job_sequencer.md
Name: miner_job_sequencer

Overview:
- Sequences one skein miner instance through discrete work jobs.
- Accepts a job (640-bit block, start nonce, scan length) via valid/ready.
- Drives the miner's reset/block/nonce_start, discards results during pipeline fill, then scans for a fixed number of cycles.
- Queues found nonces in a small result FIFO for the host-side AXI register logic.

Parameters:
- CORES, 1: nonce stride per cycle of the attached miner.
- OFFSET, 733: miner pipeline latency in cycles; hits are discarded for this long after load.
- RESULT_DEPTH, 4: result FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- job_valid  in  1  job offer
- job_ready  out  1  job accepted when job_valid && job_ready
- job_block  in  640  midstate/data/target word for the miner
- job_nonce_start  in  32  first nonce of the job
- job_cycles  in  32  number of scan cycles; job covers job_cycles*CORES nonces
- abort  in  1  single-cycle request to cancel the current job
- miner_reset  out  1  to miner reset
- miner_block  out  640  to miner block, registered
- miner_nonce_start  out  32  to miner nonce_start, registered
- miner_nonce_found  in  1  from miner
- miner_nonce_out  in  32  from miner
- res_valid  out  1  FIFO not empty
- res_ready  in  1  pop when res_valid && res_ready
- res_nonce  out  32  FIFO head
- busy  out  1  state != IDLE
- job_done  out  1  one-cycle pulse at normal job completion
- drop_count  out  16  saturating count of hits lost to a full FIFO

Behaviour:
- Reset values:
  - State IDLE; miner_reset=1.
  - miner_block=0, miner_nonce_start=0.
  - FIFO empty: res_valid=0, res_nonce=0.
  - busy=0, job_done=0, drop_count=0, job_ready=0 during reset.
  - Reset mid-job takes effect next edge; the job is lost and no job_done pulse is produced.
- job_ready = (state==IDLE) && !abort. Abort has priority over a simultaneous offer.
- On accept, latch job_block into miner_block, job_nonce_start into miner_nonce_start, and job_cycles into a remaining counter.
  - job_cycles==0: stay IDLE, pulse job_done on the next cycle, miner_reset stays 1.
  - Otherwise go to LOAD.
- States:
  - IDLE: miner_reset=1.
  - LOAD: miner_reset=1 for exactly 2 cycles, which covers the miner's internal reset register. Then go to FLUSH.
  - FLUSH: miner_reset=0. Count OFFSET cycles; miner_nonce_found is ignored. After OFFSET cycles go to SCAN.
  - SCAN: miner_reset=0. Each cycle:
    - If miner_nonce_found=1, push miner_nonce_out into the FIFO.
    - Decrement remaining. The cycle where remaining==1 is the last sampled cycle.
    - After that cycle go to IDLE and pulse job_done in the same cycle as the IDLE entry.
- abort in LOAD, FLUSH or SCAN: next state IDLE with miner_reset=1 and no job_done. A hit sampled in the abort cycle is still pushed. abort in IDLE has no effect.
- Latency: the first SCAN sample occurs 2+OFFSET cycles after the accept edge; total job length is 2+OFFSET+job_cycles cycles.
- FIFO:
  - Push when full and no pop in the same cycle: drop the push and increment drop_count, saturating at 0xFFFF.
  - Simultaneous push and pop when full: both succeed, count unchanged.
  - Simultaneous push and pop when empty: the push is written; res_valid rises next cycle.
  - Pointers wrap modulo RESULT_DEPTH.
  - The FIFO persists across jobs and aborts; only reset clears it.
- Nonce arithmetic is modulo 2^32 inside the miner; the sequencer does no range checks. A wrapping job is legal.
- miner_block and miner_nonce_start hold their values until the next accept.

Test Plan:
- Basic job: nonce_start=0x100, job_cycles=10, OFFSET=4, miner model flags nonce 0x105 -> job_ready low for 16 cycles, res_nonce=0x105, exactly one job_done pulse, busy falls with IDLE entry.
- Flush discard: model asserts found during every FLUSH cycle and never in SCAN -> FIFO stays empty, drop_count=0.
- Overflow: RESULT_DEPTH=4, found every SCAN cycle, job_cycles=6, res_ready=0 -> 4 entries in push order, drop_count=2; then pop all -> res_valid falls after the 4th pop.
- Zero-length and back-to-back: job_cycles=0 -> miner_reset never falls, job_done one cycle later. A second job offered the following cycle is accepted.
- Abort mid-SCAN: abort at SCAN cycle 3 of 20 with a simultaneous hit -> hit stored, no job_done, miner_reset=1 the next cycle, job_ready=1 the cycle after.
- Reset mid-FLUSH with FIFO holding 2 entries -> all outputs at reset values the next cycle, drop_count=0.
